// File: rtl/wb_spi_master_mc.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : wb_spi_master_mc                                                |
// | Purpose  : Wishbone-slave SPI master, four SPI modes, programmable SCK     |
// |            divider, 1..DATA_W-bit transfers, MSB/LSB-first, NUM_CS        |
// |            one-hot chip selects. Single TX/RX register, no FIFO.           |
// | Options  : SPI_IRQ_EN - adds IRQ_O = CTRL.IE & STAT.DONE (registered).     |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module wb_spi_master_mc #(
  parameter int DATA_W = 32,
  parameter int NUM_CS = 4,
  parameter int DIV_W  = 8
) (
  input  logic              CLK_I,
  input  logic              RST_I,
  input  logic [7:0]        ADR_I,
  input  logic              CYC_I,
  input  logic              STB_I,
  input  logic              WE_I,
  input  logic [DATA_W-1:0] DAT_I,
  output logic [DATA_W-1:0] DAT_O,
  output logic              ACK_O,
  output logic              SPI_CLK,
  output logic              SPI_MOSI,
  input  logic              SPI_MISO,
  output logic [NUM_CS-1:0] SPI_CS_N,
  output logic              SPI_WP_N,
  output logic              SPI_HOLD_N
`ifdef SPI_IRQ_EN
  ,
  output logic              IRQ_O
`endif
);

  localparam int IW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [4:0] LEN_MAX = 5'(DATA_W - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    SHIFT = 2'd2,
    HOLD  = 2'd3
  } state_t;

  // Bus decode
  logic [31:0] wdat;
  logic        req, wr_req, ctrl_wr, tx_wr, stat_wr, start;

  // Programmer-visible control register
  logic             ctrl_cpha, ctrl_cpol, ctrl_lsb;
  logic [2:0]       ctrl_cs;
  logic [DIV_W-1:0] ctrl_div;
  logic [4:0]       ctrl_len;
  logic             ctrl_wp, ctrl_hold;
`ifdef SPI_IRQ_EN
  logic             ctrl_ie;
  logic             irq;
`endif

  // Per-transfer configuration, frozen when the transfer is launched
  logic             cfg_cpha, cfg_cpol, cfg_lsb;
  logic [2:0]       cfg_cs;
  logic [DIV_W-1:0] cfg_div;
  logic [IW-1:0]    cfg_len_m1;

  // Engine state
  state_t              state;
  logic [DIV_W-1:0]    div_cnt;
  logic [IW-1:0]       bit_cnt;
  logic                phase;       // 0: next SCK edge is the leading one
  logic                shift_done;
  logic                go;
  logic                busy, done, err;
  logic [DATA_W-1:0]   tx_data, rx_sh, rx_data;
  logic                sck, mosi, ack;
  logic [NUM_CS-1:0]   cs_n;
  logic [DATA_W-1:0]   dat_o;

  // Datapath helpers
  logic [4:0]        len_lim;
  logic [IW-1:0]     cur_idx, nxt_cnt, nxt_idx, first_idx;
  logic              tick, do_edge;
  logic [NUM_CS-1:0] cs_sel_n;
  logic [31:0]       ctrl_rd, rd_data;
  logic              unused_bits;

  assign wdat    = 32'(DAT_I);
  assign req     = CYC_I & STB_I & ~ack;
  assign wr_req  = req & WE_I;
  assign ctrl_wr = wr_req & (ADR_I[1:0] == 2'd0);
  assign tx_wr   = wr_req & (ADR_I[1:0] == 2'd1);
  assign stat_wr = wr_req & (ADR_I[1:0] == 2'd3);
  assign start   = tx_wr & ~busy;

  // Lengths longer than the shift register are clamped to DATA_W bits
  assign len_lim   = (ctrl_len > LEN_MAX) ? LEN_MAX : ctrl_len;

  assign cur_idx   = cfg_lsb ? bit_cnt : cfg_len_m1 - bit_cnt;
  assign nxt_cnt   = (bit_cnt == cfg_len_m1) ? '0 : bit_cnt + IW'(1);
  assign nxt_idx   = cfg_lsb ? nxt_cnt : cfg_len_m1 - nxt_cnt;
  assign first_idx = cfg_lsb ? '0 : cfg_len_m1;

  assign tick    = (div_cnt == cfg_div);
  assign do_edge = tick & ((state == SETUP) | ((state == SHIFT) & ~shift_done));

  // An out-of-range index matches no output, so no device is selected
  for (genvar i = 0; i < NUM_CS; i++) begin : g_cs_sel
    assign cs_sel_n[i] = (cfg_cs != 3'(i));
  end

  assign unused_bits = ^{ADR_I[7:2], wdat, len_lim};

  // CTRL read-back image
  always_comb begin
    ctrl_rd            = '0;
    ctrl_rd[0]         = ctrl_cpha;
    ctrl_rd[1]         = ctrl_cpol;
    ctrl_rd[2]         = ctrl_lsb;
`ifdef SPI_IRQ_EN
    ctrl_rd[3]         = ctrl_ie;
`endif
    ctrl_rd[6:4]       = ctrl_cs;
    ctrl_rd[DIV_W+7:8] = ctrl_div;
    ctrl_rd[20:16]     = ctrl_len;
    ctrl_rd[30]        = ctrl_wp;
    ctrl_rd[31]        = ctrl_hold;
  end

  // Register read multiplexer
  always_comb begin
    rd_data = '0;
    case (ADR_I[1:0])
      2'd0:    rd_data = ctrl_rd;
      2'd1:    rd_data = 32'(tx_data);
      2'd2:    rd_data = 32'(rx_data);
      default: rd_data = {29'd0, err, done, busy};
    endcase
  end

  // Wishbone handshake, registered read data and CTRL storage
  always_ff @(posedge CLK_I) begin
    if (!RST_I) begin
      ack       <= 1'b0;
      dat_o     <= '0;
      ctrl_cpha <= 1'b0;
      ctrl_cpol <= 1'b0;
      ctrl_lsb  <= 1'b0;
      ctrl_cs   <= '0;
      ctrl_div  <= '0;
      ctrl_len  <= '0;
      ctrl_wp   <= 1'b1;
      ctrl_hold <= 1'b1;
`ifdef SPI_IRQ_EN
      ctrl_ie   <= 1'b0;
`endif
    end else begin
      ack <= req;
      if (req && !WE_I) begin
        dat_o <= rd_data[DATA_W-1:0];
      end
      if (ctrl_wr) begin
        ctrl_cpha <= wdat[0];
        ctrl_cpol <= wdat[1];
        ctrl_lsb  <= wdat[2];
        ctrl_cs   <= wdat[6:4];
        ctrl_div  <= wdat[DIV_W+7:8];
        ctrl_len  <= wdat[20:16];
        ctrl_wp   <= wdat[30];
        ctrl_hold <= wdat[31];
`ifdef SPI_IRQ_EN
        ctrl_ie   <= wdat[3];
`endif
      end
    end
  end

  // Transfer engine: status flags, SCK/MOSI/CS generation and MISO capture
  always_ff @(posedge CLK_I) begin
    if (!RST_I) begin
      state      <= IDLE;
      div_cnt    <= '0;
      bit_cnt    <= '0;
      phase      <= 1'b0;
      shift_done <= 1'b0;
      go         <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      tx_data    <= '0;
      rx_sh      <= '0;
      rx_data    <= '0;
      sck        <= 1'b0;
      mosi       <= 1'b0;
      cs_n       <= '1;
      cfg_cpha   <= 1'b0;
      cfg_cpol   <= 1'b0;
      cfg_lsb    <= 1'b0;
      cfg_cs     <= '0;
      cfg_div    <= '0;
      cfg_len_m1 <= '0;
    end else begin
      // W1C first so that a same-cycle hardware set below takes priority
      if (stat_wr && wdat[1]) done <= 1'b0;
      if (stat_wr && wdat[2]) err  <= 1'b0;
      if (tx_wr && busy)      err  <= 1'b1;

      go <= start;
      if (start) begin
        busy       <= 1'b1;
        tx_data    <= DAT_I;
        cfg_cpha   <= ctrl_cpha;
        cfg_cpol   <= ctrl_cpol;
        cfg_lsb    <= ctrl_lsb;
        cfg_cs     <= ctrl_cs;
        cfg_div    <= ctrl_div;
        cfg_len_m1 <= len_lim[IW-1:0];
      end

      if (state != IDLE) begin
        div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);
      end

      // One SCK edge per half-period; leading/trailing roles swap with CPHA
      if (do_edge) begin
        sck   <= ~sck;
        phase <= ~phase;
        if (!phase) begin
          if (cfg_cpha) mosi <= tx_data[cur_idx];
          else          rx_sh[cur_idx] <= SPI_MISO;
        end else begin
          if (cfg_cpha) rx_sh[cur_idx] <= SPI_MISO;
          else          mosi <= tx_data[nxt_idx];
          bit_cnt <= nxt_cnt;
          if (bit_cnt == cfg_len_m1) shift_done <= 1'b1;
        end
      end

      case (state)
        IDLE: begin
          sck <= ctrl_cpol;
          if (go) begin
            state      <= SETUP;
            cs_n       <= cs_sel_n;
            mosi       <= tx_data[first_idx];
            sck        <= cfg_cpol;
            div_cnt    <= '0;
            bit_cnt    <= '0;
            phase      <= 1'b0;
            shift_done <= 1'b0;
            rx_sh      <= '0;
          end
        end
        SETUP: begin
          if (tick) state <= SHIFT;
        end
        SHIFT: begin
          if (tick && shift_done) state <= HOLD;
        end
        HOLD: begin
          if (tick) begin
            state   <= IDLE;
            cs_n    <= '1;
            mosi    <= 1'b0;
            rx_data <= rx_sh;
            done    <= 1'b1;
            busy    <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SPI_IRQ_EN
  // Interrupt follows DONE one cycle later when enabled
  always_ff @(posedge CLK_I) begin
    if (!RST_I) irq <= 1'b0;
    else        irq <= ctrl_ie & done;
  end
  assign IRQ_O = irq;
`endif

  assign ACK_O      = ack;
  assign DAT_O      = dat_o;
  assign SPI_CLK    = sck;
  assign SPI_MOSI   = mosi;
  assign SPI_CS_N   = cs_n;
  assign SPI_WP_N   = ctrl_wp;
  assign SPI_HOLD_N = ctrl_hold;

endmodule
`default_nettype wire
